keypad_scanner: RTL and testbench

//   Drives the 4x4 keypad columns and reads the row lines. Rows are also

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_scanner.sv | 133 +++++++++++++
 tb/tb_keypad_scanner.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and row/column decode helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    CONFIRM = 2'd1,
    RELEASE = 2'd2
  } scan_state_t;

  localparam int          NUM_ROWS  = 4;
  localparam int          NUM_COLS  = 4;
  localparam logic [3:0]  COL_RESET = 4'b1110;
  localparam logic [3:0]  ROWS_IDLE = 4'hF;

  // Position of the low bit in an active-low one-hot nibble (0 when not one-hot).
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // {onehot_ok, idx}: onehot_ok is set only when exactly one row is pulled low.
  function automatic logic [2:0] row_encode(input logic [3:0] rows);
    logic ok;
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return {ok, low_index(rows)};
  endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: settles each column, confirms a stable press,
// emits one key event per press and waits for a clean release before moving on.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYC  = 8,
  parameter int PRESS_CYC   = 16,
  parameter int RELEASE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] filas_in,
  input  logic       estable_in,
  output logic [3:0] columnas_out,
  output logic [3:0] tecla_out,
  output logic       tecla_valida
);

  localparam int MAX_AB  = (SETTLE_CYC > PRESS_CYC) ? SETTLE_CYC : PRESS_CYC;
  localparam int MAX_CYC = (MAX_AB > RELEASE_CYC) ? MAX_AB : RELEASE_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CYC - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYC - 1);

  scan_state_t      state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       col_r, col_s;
  logic [3:0]       seen_r, seen_s;
  logic [3:0]       tecla_r, tecla_s;
  logic             valid_r, valid_s;
  logic [2:0]       row_enc_s;
  logic [3:0]       col_next_s;

  // State, counter, column ring and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= SCAN;
      cnt_r   <= CNT_ZERO;
      col_r   <= COL_RESET;
      seen_r  <= ROWS_IDLE;
      tecla_r <= 4'h0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      col_r   <= col_s;
      seen_r  <= seen_s;
      tecla_r <= tecla_s;
      valid_r <= valid_s;
    end
  end

  // Next-state decode; the valid pulse defaults low so it lasts one cycle only.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    col_s      = col_r;
    seen_s     = seen_r;
    tecla_s    = tecla_r;
    valid_s    = 1'b0;
    row_enc_s  = row_encode(filas_in);
    col_next_s = {col_r[2:0], col_r[3]};

    case (state_r)
      SCAN: begin
        if (cnt_r != SETTLE_LAST) begin
          cnt_s = cnt_r + CNT_ONE;
        end else if (estable_in) begin
          if (filas_in == ROWS_IDLE) begin
            col_s = col_next_s;
            cnt_s = CNT_ZERO;
          end else begin
            seen_s  = filas_in;
            cnt_s   = CNT_ZERO;
            state_s = CONFIRM;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end

      CONFIRM: begin
        if (estable_in && (filas_in == seen_r) && (filas_in != ROWS_IDLE)) begin
          if (cnt_r == PRESS_LAST) begin
            // Ghosted / multi-key patterns are swallowed but still need a release.
            if (row_enc_s[2]) begin
              tecla_s = {row_enc_s[1:0], low_index(col_r)};
              valid_s = 1'b1;
            end else begin
              tecla_s = tecla_r;
            end
            cnt_s   = CNT_ZERO;
            state_s = RELEASE;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s   = CNT_ZERO;
          state_s = SCAN;
        end
      end

      RELEASE: begin
        if (estable_in && (filas_in == ROWS_IDLE)) begin
          if (cnt_r == RELEASE_LAST) begin
            col_s   = col_next_s;
            cnt_s   = CNT_ZERO;
            state_s = SCAN;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_s = CNT_ZERO;
        end
      end

      default: begin
        state_s = SCAN;
        cnt_s   = CNT_ZERO;
        col_s   = COL_RESET;
      end
    endcase
  end

  assign columnas_out = col_r;
  assign tecla_out    = tecla_r;
  assign tecla_valida = valid_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench: a keypad matrix and debounce model drive the scanner,
// and a behavioural reference predicts columns, key index and valid pulse.
module tb_keypad_scanner;

  localparam int SETTLE  = 8;
  localparam int PRESS   = 16;
  localparam int RELEASE = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] filas_in;
  logic       estable_in;
  logic [3:0] columnas_out;
  logic [3:0] tecla_out;
  logic       tecla_valida;

  keypad_scanner #(
    .SETTLE_CYC (SETTLE),
    .PRESS_CYC  (PRESS),
    .RELEASE_CYC(RELEASE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .filas_in    (filas_in),
    .estable_in  (estable_in),
    .columnas_out(columnas_out),
    .tecla_out   (tecla_out),
    .tecla_valida(tecla_valida)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] pressed;     // bit r*4+c: key at row r, column c held down
  int          glitch;      // cycles left with rows forced idle
  logic        rst_req;
  logic [3:0]  h0, h1, h2;  // previous row samples seen by the debouncer

  int         m_col, m_mode, m_run;  // mode 0 scanning, 1 confirming, 2 awaiting release
  logic [3:0] m_seen, m_key;
  logic       m_valid;

  int         pulses;
  logic [3:0] last_key;
  logic [3:0] k1;
  int         waited;

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_col   = 0;
    m_mode  = 0;
    m_run   = 0;
    m_seen  = 4'hF;
    m_key   = 4'h0;
    m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] f;
    int idx;
    f = filas_in;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_valid = 1'b0;
      if (m_mode == 0) begin
        if (m_run < SETTLE - 1) m_run++;
        else if (estable_in) begin
          m_run = 0;
          if (f == 4'hF) m_col = (m_col + 1) % 4;
          else begin
            m_seen = f;
            m_mode = 1;
          end
        end
      end else if (m_mode == 1) begin
        if (estable_in && f == m_seen) begin
          m_run++;
          if (m_run == PRESS) begin
            if ($countones(~f) == 1) begin
              idx = 0;
              for (int r = 0; r < 4; r++) if (!f[r]) idx = r;
              m_key   = 4'(idx * 4 + m_col);
              m_valid = 1'b1;
            end
            m_mode = 2;
            m_run  = 0;
          end
        end else begin
          m_mode = 0;
          m_run  = 0;
        end
      end else begin
        if (estable_in && f == 4'hF) begin
          m_run++;
          if (m_run == RELEASE) begin
            m_col  = (m_col + 1) % 4;
            m_mode = 0;
            m_run  = 0;
          end
        end else begin
          m_run = 0;
        end
      end
    end
    h2 = h1;
    h1 = h0;
    h0 = f;
  endtask

  task automatic drive();
    logic [3:0] f;
    f = 4'hF;
    if (glitch > 0) glitch--;
    else for (int r = 0; r < 4; r++) if (pressed[r*4 + m_col]) f[r] = 1'b0;
    filas_in   = f;
    estable_in = (f == h0) && (h0 == h1) && (h1 == h2);
    rst_n      = !rst_req;
    if (!rst_n) begin
      #1;
      check4("rst_cols", columnas_out, 4'b1110);
      check4("rst_key", tecla_out, 4'h0);
      check4("rst_valid", {3'b000, tecla_valida}, 4'h0);
    end
  endtask

  task automatic cycle();
    logic [3:0] ecol;
    logic [3:0] one;
    @(negedge clk);
    drive();
    @(posedge clk);
    model_step();
    #1;
    one  = 4'b0001;
    ecol = ~(one << m_col);
    check4("cols", columnas_out, ecol);
    check4("key", tecla_out, m_key);
    check4("valid", {3'b000, tecla_valida}, {3'b000, m_valid});
    if (tecla_valida) begin
      pulses++;
      last_key = tecla_out;
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    rst_n      = 1'b0;
    rst_req    = 1'b1;
    filas_in   = 4'hF;
    estable_in = 1'b1;
    h0 = 4'hF; h1 = 4'hF; h2 = 4'hF;
    pressed  = 16'h0000;
    glitch   = 0;
    pulses   = 0;
    last_key = 4'h0;
    model_reset();

    // 1: reset then idle scanning
    run(3);
    rst_req = 1'b0;
    run(40);
    checkn("t1_pulses", pulses, 0);

    // 2: row 2 on column 1
    pulses  = 0;
    pressed = 16'h0200;
    run(80);
    checkn("t2_pulses", pulses, 1);
    check4("t2_key", last_key, 4'b1001);
    check4("t2_frozen", columnas_out, 4'b1101);
    pressed = 16'h0000;
    run(40);

    // 3: glitchy press on row 1 / column 3, then clean
    pulses  = 0;
    pressed = 16'h0080;
    for (int i = 0; i < 8; i++) begin
      glitch = 3;
      run(10);
    end
    checkn("t3_glitch_pulses", pulses, 0);
    run(80);
    checkn("t3_pulses", pulses, 1);
    check4("t3_key", last_key, 4'b0111);
    pressed = 16'h0000;
    run(40);

    // 4: two keys on column 0 (rows 0011)
    pulses  = 0;
    pressed = 16'h1100;
    run(80);
    checkn("t4_pulses", pulses, 0);
    check4("t4_frozen", columnas_out, 4'b1110);
    pressed = 16'h0000;
    run(60);

    // 5: reset mid-confirm
    pulses  = 0;
    pressed = 16'h0004;
    waited  = 0;
    while (!(m_mode == 1 && m_run >= 4) && waited < 300) begin
      cycle();
      waited++;
    end
    checkn("t5_reached_confirm", (waited < 300) ? 1 : 0, 1);
    rst_req = 1'b1;
    pressed = 16'h0000;
    cycle();
    rst_req = 1'b0;
    run(60);
    checkn("t5_pulses", pulses, 0);

    // 6: long hold, release, press again
    pulses  = 0;
    pressed = 16'h4000;
    run(1000);
    checkn("t6_hold_pulses", pulses, 1);
    k1 = last_key;
    check4("t6_key1", k1, 4'b1110);
    pressed = 16'h0000;
    run(60);
    pressed = 16'h4000;
    run(100);
    pressed = 16'h0000;
    run(60);
    checkn("t6_pulses", pulses, 2);
    check4("t6_key2", last_key, k1);

    // random presses, ghosting, glitches and bounces against the model
    for (int e = 0; e < 25; e++) begin
      pressed = 16'h0001 << $urandom_range(0, 15);
      if ($urandom_range(0, 3) == 0) pressed = pressed | (16'h0001 << $urandom_range(0, 15));
      for (int j = 0; j < 6; j++) begin
        if ($urandom_range(0, 5) == 0) glitch = $urandom_range(1, 4);
        run($urandom_range(3, 15));
      end
      pressed = 16'h0000;
      run($urandom_range(5, 50));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
